// File: rtl/arm9_timer_bank.sv
// arm9_timer_bank
//   Bus-attached bank of NCH programmable down-counter timers on the ram_* data
//   port. Each channel has a reload value (LOAD), a live counter (VALUE), a
//   control word (EN / ONESHOT / IEN) and one bit in a shared write-1-to-clear
//   STATUS register. irq is a level output: the OR of all pending, enabled
//   channels.
//
//   Register window (512 bytes at BASE_ADDR), channel c at offset 16*c:
//     +0x0 CTRL  bit0 EN, bit1 ONESHOT, bit2 IEN
//     +0x4 LOAD  reload value (CNT_W bits)
//     +0x8 VALUE current count (read-only)
//     0x100 STATUS (W1C), 0x104 PRESCALE (only with ARM9_TIMER_PRESCALE_EN)
//
//   Optional feature macro: ARM9_TIMER_PRESCALE_EN adds a 16-bit shared
//   prescaler so counters tick once every PRESCALE+1 clk cycles.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   ram_cen      bus access strobe
//   ram_wen      1 = write, 0 = read
//   ram_flag     write byte enables (bit n -> wdata[8n+7:8n])
//   ram_addr     byte address (word aligned)
//   ram_wdata    write data
//   ram_rdata    registered read data (valid the cycle after the request)
//   irq          OR of irq_vec
//   irq_vec      per-channel STATUS & IEN
module arm9_timer_bank #(
  parameter int          NCH       = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hE0001000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ram_cen,
  input  logic           ram_wen,
  input  logic [3:0]     ram_flag,
  input  logic [31:0]    ram_addr,
  input  logic [31:0]    ram_wdata,
  output logic [31:0]    ram_rdata,
  output logic           irq,
  output logic [NCH-1:0] irq_vec
);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic             hit, wr_acc, rd_acc;
  logic [8:0]       off;
  logic [3:0]       ch_sel;
  logic [1:0]       reg_sel;
  logic             wr_status;
  logic [NCH-1:0]   wr_ctrl, wr_load;
  logic [NCH-1:0]   en_q, os_q, ien_q, status_q;
  logic [CNT_W-1:0] load_q  [NCH];
  logic [CNT_W-1:0] value_q [NCH];
  logic [31:0]      load_wr_val [NCH];
  logic [NCH-1:0]   run, expire, reload, ctrl_wr;
  logic [NCH-1:0]   status_clr;
  logic [31:0]      rd_mux;
  logic             tick;
  logic             unused_addr_bits;

  assign unused_addr_bits = &{1'b0, ram_addr[1:0]};

`ifdef ARM9_TIMER_PRESCALE_EN
  logic [15:0] presc_q, pcnt_q;
  logic        wr_presc;

  assign wr_presc = wr_acc & (off == 9'h104);
  assign tick     = (pcnt_q == presc_q);

  // Writing PRESCALE restarts the shared divider from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (wr_presc) begin
      if (ram_flag[0]) presc_q[7:0]  <= ram_wdata[7:0];
      if (ram_flag[1]) presc_q[15:8] <= ram_wdata[15:8];
      pcnt_q <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Address decode and read mux
  always_comb begin
    hit       = (ram_addr[31:9] == BASE_ADDR[31:9]);
    wr_acc    = ram_cen & ram_wen & hit;
    rd_acc    = ram_cen & ~ram_wen & hit;
    off       = ram_addr[8:0];
    ch_sel    = off[7:4];
    reg_sel   = off[3:2];
    wr_ctrl   = '0;
    wr_load   = '0;
    rd_mux    = '0;
    wr_status = wr_acc & (off == 9'h100);
    for (int c = 0; c < NCH; c++) begin
      if (!off[8] && ch_sel == 4'(c)) begin
        case (reg_sel)
          2'd0: begin
            wr_ctrl[c] = wr_acc;
            rd_mux     = {29'b0, ien_q[c], os_q[c], en_q[c]};
          end
          2'd1: begin
            wr_load[c] = wr_acc;
            rd_mux     = 32'(load_q[c]);
          end
          2'd2:    rd_mux = 32'(value_q[c]);
          default: rd_mux = '0;
        endcase
      end
    end
    if (off == 9'h100) rd_mux = 32'(status_q);
`ifdef ARM9_TIMER_PRESCALE_EN
    if (off == 9'h104) rd_mux = {16'b0, presc_q};
`endif
  end

  // Per-channel next-state terms
  always_comb begin
    status_clr = (wr_status & ram_flag[0]) ? ram_wdata[NCH-1:0] : '0;
    for (int c = 0; c < NCH; c++) begin
      load_wr_val[c] = merge_bytes(32'(load_q[c]), ram_wdata, ram_flag);
      ctrl_wr[c]     = wr_ctrl[c] & ram_flag[0];
      // A software write that clears EN freezes VALUE at this edge.
      run[c]         = en_q[c] & tick & ~(ctrl_wr[c] & ~ram_wdata[0]);
      expire[c]      = run[c] & (value_q[c] == '0);
      // Reload on 0->1 enable, on periodic expiry, and when a software EN=1
      // write lands on the same edge as a one-shot expiry.
      reload[c]      = (ctrl_wr[c] & ram_wdata[0] & (~en_q[c] | (expire[c] & os_q[c])))
                     | (expire[c] & ~os_q[c]);
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= '0;
      os_q     <= '0;
      ien_q    <= '0;
      status_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        load_q[c]  <= '0;
        value_q[c] <= '0;
      end
    end else begin
      // Hardware set wins over a simultaneous W1C.
      status_q <= (status_q & ~status_clr) | expire;
      for (int c = 0; c < NCH; c++) begin
        if (ctrl_wr[c]) begin
          en_q[c]  <= ram_wdata[0];
          os_q[c]  <= ram_wdata[1];
          ien_q[c] <= ram_wdata[2];
        end else if (expire[c] & os_q[c]) begin
          en_q[c] <= 1'b0;
        end
        if (wr_load[c]) load_q[c] <= load_wr_val[c][CNT_W-1:0];
        if (reload[c])
          value_q[c] <= load_q[c];
        else if (run[c] && value_q[c] != '0)
          value_q[c] <= value_q[c] - CNT_W'(1);
      end
    end
  end

  // Registered read data; non-hit cycles hold the last value.
  always_ff @(posedge clk) begin
    if (rst)         ram_rdata <= '0;
    else if (rd_acc) ram_rdata <= rd_mux;
  end

  assign irq_vec = status_q & ien_q;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_arm9_timer_bank.sv
module tb_arm9_timer_bank;
  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'hE0001000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ram_cen = 1'b0;
  logic           ram_wen = 1'b0;
  logic [3:0]     ram_flag = 4'h0;
  logic [31:0]    ram_addr = 32'h0;
  logic [31:0]    ram_wdata = 32'h0;
  logic [31:0]    ram_rdata;
  logic           irq;
  logic [NCH-1:0] irq_vec;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  arm9_timer_bank #(.NCH(NCH), .CNT_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .ram_cen(ram_cen), .ram_wen(ram_wen),
    .ram_flag(ram_flag), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus tasks are entered at a negedge and return at the next negedge.
  task automatic bus_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
    ram_cen = 1'b1; ram_wen = 1'b1; ram_addr = BASE + off; ram_wdata = d; ram_flag = be;
    @(negedge clk);
    ram_cen = 1'b0; ram_wen = 1'b0; ram_flag = 4'h0;
  endtask

  task automatic bus_read_abs(input logic [31:0] addr, output logic [31:0] d);
    ram_cen = 1'b1; ram_wen = 1'b0; ram_addr = addr;
    @(negedge clk);
    ram_cen = 1'b0;
    d = ram_rdata;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
    bus_read_abs(BASE + off, d);
  endtask

  task automatic wait_vec(input int idx, input int budget, output int t, output bit ok);
    int n;
    n = 0;
    while (!irq_vec[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = irq_vec[idx];
    t  = cyc;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    tests++; if (ram_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", ram_rdata); end
    tests++; if (irq !== 1'b0 || irq_vec !== '0) begin fails++; $display("FAIL reset_irq got %b/%b want 0/0", irq, irq_vec); end
    bus_read(32'h000, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl0 got %h want 0", d); end
    bus_read(32'h004, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_load0 got %h want 0", d); end
    bus_read(32'h008, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_value0 got %h want 0", d); end
    bus_read(32'h100, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status got %h want 0", d); end
  endtask

  task automatic test_periodic_irq;
    int t0, t1, t2;
    bit ok;
    bus_write(32'h004, 32'd9999, 4'hF);
    // read latency: data must not appear before the clock edge
    ram_cen = 1'b1; ram_wen = 1'b0; ram_addr = BASE + 32'h004;
    #1;
    tests++; if (ram_rdata !== 32'h0) begin fails++; $display("FAIL rd_latency_early got %h want 0", ram_rdata); end
    @(negedge clk);
    ram_cen = 1'b0;
    tests++; if (ram_rdata !== 32'd9999) begin fails++; $display("FAIL rd_latency_data got %0d want 9999", ram_rdata); end
    bus_write(32'h000, 32'h5, 4'hF);
    t0 = cyc;
    while (!irq && cyc - t0 < 10100) @(negedge clk);
    ok = irq; t1 = cyc;
    tests++; if (!ok || t1 - t0 != 10000) begin fails++; $display("FAIL irq_first got %0d cycles (irq=%b) want 10000", t1 - t0, ok); end
    bus_write(32'h100, 32'h1, 4'hF);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL w1c_clear irq got %b want 0", irq); end
    while (!irq && cyc - t1 < 10100) @(negedge clk);
    ok = irq; t2 = cyc;
    tests++; if (!ok || t2 - t1 != 10000) begin fails++; $display("FAIL irq_period got %0d cycles (irq=%b) want 10000", t2 - t1, ok); end
    bus_write(32'h000, 32'h0, 4'hF);
    bus_write(32'h100, 32'h1, 4'hF);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL ch0_off irq got %b want 0", irq); end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    int t0, t1, sets;
    bit ok;
    bus_write(32'h014, 32'd3, 4'hF);
    bus_write(32'h010, 32'h7, 4'hF);
    t0 = cyc;
    wait_vec(1, 20, t1, ok);
    tests++; if (!ok || t1 - t0 != 4) begin fails++; $display("FAIL oneshot_delay got %0d (set=%b) want 4", t1 - t0, ok); end
    bus_read(32'h010, d);
    tests++; if (d !== 32'h6) begin fails++; $display("FAIL oneshot_ctrl got %h want 6", d); end
    bus_read(32'h018, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL oneshot_value got %h want 0", d); end
    bus_write(32'h100, 32'h2, 4'hF);
    sets = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (irq_vec[1]) sets++;
    end
    tests++; if (sets != 0) begin fails++; $display("FAIL oneshot_rearm got %0d set cycles want 0", sets); end
  endtask

  task automatic test_zero_reload;
    logic [31:0] d;
    bus_write(32'h024, 32'h0, 4'hF);
    bus_write(32'h020, 32'h1, 4'hF);
    @(negedge clk);
    // W1C immediately followed by a read of the post-W1C state
    bus_write(32'h100, 32'h4, 4'hF);
    bus_read(32'h100, d);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL w1c_vs_set got %h want 4", d); end
    bus_read(32'h100, d);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL load0_every_cycle got %h want 4", d); end
    tests++; if (irq !== 1'b0 || irq_vec !== '0) begin fails++; $display("FAIL ien0_masked got %b/%b want 0/0", irq, irq_vec); end
    bus_write(32'h020, 32'h0, 4'hF);
    bus_write(32'h100, 32'h4, 4'hF);
    bus_read(32'h100, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL ch2_stop_status got %h want 0", d); end
  endtask

  task automatic test_load_running;
    logic [31:0] d;
    bus_write(32'h034, 32'd100, 4'hF);
    bus_write(32'h030, 32'h1, 4'hF);
    bus_read(32'h038, d);
    tests++; if (d !== 32'd100) begin fails++; $display("FAIL enable_reload got %0d want 100", d); end
    bus_write(32'h034, 32'd5, 4'hF);
    bus_read(32'h038, d);
    tests++; if (d !== 32'd98) begin fails++; $display("FAIL load_while_run got %0d want 98", d); end
    bus_write(32'h030, 32'h0, 4'hF);
    bus_read(32'h038, d);
    tests++; if (d !== 32'd97) begin fails++; $display("FAIL freeze got %0d want 97", d); end
    bus_write(32'h030, 32'h1, 4'hF);
    bus_read(32'h038, d);
    tests++; if (d !== 32'd5) begin fails++; $display("FAIL reenable_reload got %0d want 5", d); end
    bus_write(32'h030, 32'h1, 4'hF);
    bus_read(32'h038, d);
    tests++; if (d !== 32'd3) begin fails++; $display("FAIL en_rewrite_no_reload got %0d want 3", d); end
    bus_write(32'h030, 32'h0, 4'hF);
    bus_write(32'h100, 32'h8, 4'hF);
  endtask

  task automatic test_byte_lane;
    logic [31:0] d;
    bus_write(32'h034, 32'hAABBCCDD, 4'hF);
    bus_write(32'h034, 32'h11223344, 4'b0010);
    bus_read(32'h034, d);
    tests++; if (d !== 32'hAABB33DD) begin fails++; $display("FAIL byte_lane got %h want aabb33dd", d); end
    bus_read_abs(32'h0000_1004, d);
    tests++; if (d !== 32'hAABB33DD) begin fails++; $display("FAIL nonhit_hold got %h want aabb33dd", d); end
    bus_write(32'h0FC, 32'hFFFFFFFF, 4'hF);
    bus_read(32'h0FC, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_0fc got %h want 0", d); end
    bus_write(32'h040, 32'h7, 4'hF);
    bus_write(32'h044, 32'hFFFF, 4'hF);
    bus_read(32'h040, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL chNCH_ctrl got %h want 0", d); end
    bus_read(32'h044, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL chNCH_load got %h want 0", d); end
    bus_read(32'h03C, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reserved_c got %h want 0", d); end
    repeat (5) @(negedge clk);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL unmapped_irq got %b want 0", irq); end
  endtask

  task automatic test_prescale;
    logic [31:0] d;
    int t1, t2, period;
    bit ok;
`ifdef ARM9_TIMER_PRESCALE_EN
    logic [31:0] presc_exp;
    presc_exp = 32'h4;
    period = 10;
`else
    logic [31:0] presc_exp;
    presc_exp = 32'h0;
    period = 2;
`endif
    bus_write(32'h104, 32'h4, 4'hF);
    bus_read(32'h104, d);
    tests++; if (d !== presc_exp) begin fails++; $display("FAIL prescale_reg got %h want %h", d, presc_exp); end
    bus_write(32'h004, 32'h1, 4'hF);
    bus_write(32'h000, 32'h5, 4'hF);
    wait_vec(0, 40, t1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL prescale_first got no set want set"); end
    bus_write(32'h100, 32'h1, 4'hF);
    tests++; if (irq_vec[0] !== 1'b0) begin fails++; $display("FAIL prescale_clear got %b want 0", irq_vec[0]); end
    wait_vec(0, 40, t2, ok);
    tests++; if (!ok || t2 - t1 != period) begin fails++; $display("FAIL prescale_period got %0d (set=%b) want %0d", t2 - t1, ok, period); end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] d;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (irq !== 1'b0 || irq_vec !== '0 || ram_rdata !== 32'h0) begin
      fails++; $display("FAIL midreset_out got irq=%b vec=%b rdata=%h want 0", irq, irq_vec, ram_rdata);
    end
    bus_read(32'h000, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL midreset_ctrl got %h want 0", d); end
    bus_read(32'h004, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL midreset_load got %h want 0", d); end
    bus_read(32'h008, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL midreset_value got %h want 0", d); end
    repeat (20) @(negedge clk);
    bus_read(32'h100, d);
    tests++; if (d !== 32'h0 || irq !== 1'b0) begin fails++; $display("FAIL midreset_status got %h irq=%b want 0", d, irq); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_periodic_irq();
    test_oneshot();
    test_zero_reload();
    test_load_running();
    test_byte_lane();
    test_prescale();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
